// File: rtl/game_round_controller.sv
// Bulls-and-Cows round sequencer: latches the answer in set-up, clears the guess
// datapath while arming, counts remaining tries and flags wrong/win/lose events.
module game_round_controller #(
    parameter int MAX_TRIES    = 8,
    parameter int CLEAR_CYCLES = 4
) (
    input  logic        CLK,
    input  logic        rst,
    input  logic        modeSelect,
    input  logic [15:0] answerIn,
    input  logic        answerLegal,
    input  logic        guessDone,
    input  logic        correct,
    output logic [15:0] answerOut,
    output logic        playClear,
    output logic        playEnable,
    output logic [7:0]  led_data,
    output logic        evtWrong,
    output logic        evtWin,
    output logic        evtLose,
    output logic [2:0]  roundState
);

    localparam int TW = $clog2(MAX_TRIES + 1);

    typedef enum logic [2:0] {
        SETUP = 3'd0,
        ARM   = 3'd1,
        PLAY  = 3'd2,
        WIN   = 3'd3,
        LOSE  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [15:0]   answer_q, answer_d;
    logic          answer_valid_q, answer_valid_d;
    logic [TW-1:0] tries_q, tries_d;
    logic [7:0]    clr_cnt_q, clr_cnt_d;
    logic          gd_prev_q;
    logic [7:0]    led_q, led_d;
    logic          play_clear_q, play_clear_d;
    logic          play_enable_q, play_enable_d;
    logic          evt_wrong_q, evt_wrong_d;
    logic          evt_win_q, evt_win_d;
    logic          evt_lose_q, evt_lose_d;

    logic guess_edge;
    assign guess_edge = guessDone & ~gd_prev_q;

    // State register (all outputs are registered here too)
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q        <= SETUP;
            answer_q       <= 16'h0000;
            answer_valid_q <= 1'b0;
            tries_q        <= '0;
            clr_cnt_q      <= 8'd0;
            gd_prev_q      <= 1'b0;
            led_q          <= 8'h00;
            play_clear_q   <= 1'b1;
            play_enable_q  <= 1'b0;
            evt_wrong_q    <= 1'b0;
            evt_win_q      <= 1'b0;
            evt_lose_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            answer_q       <= answer_d;
            answer_valid_q <= answer_valid_d;
            tries_q        <= tries_d;
            clr_cnt_q      <= clr_cnt_d;
            gd_prev_q      <= guessDone;
            led_q          <= led_d;
            play_clear_q   <= play_clear_d;
            play_enable_q  <= play_enable_d;
            evt_wrong_q    <= evt_wrong_d;
            evt_win_q      <= evt_win_d;
            evt_lose_q     <= evt_lose_d;
        end
    end

    // Next-state logic; modeSelect overrides every other transition
    always_comb begin
        state_d = state_q;
        if (modeSelect) begin
            state_d = SETUP;
        end else begin
            case (state_q)
                SETUP: if (answer_valid_q) state_d = ARM;
                ARM:   if (clr_cnt_q == 8'(CLEAR_CYCLES - 1)) state_d = PLAY;
                PLAY: begin
                    if (guess_edge) begin
                        if (correct)                  state_d = WIN;
                        else if (tries_q == TW'(1))   state_d = LOSE;
                    end
                end
                WIN:     state_d = WIN;
                LOSE:    state_d = LOSE;
                default: state_d = SETUP;
            endcase
        end
    end

    // Datapath and output next values
    always_comb begin
        answer_d       = answer_q;
        answer_valid_d = answer_valid_q;
        tries_d        = tries_q;
        clr_cnt_d      = 8'd0;
        evt_wrong_d    = 1'b0;
        evt_win_d      = 1'b0;
        evt_lose_d     = 1'b0;

        if (state_q == SETUP && answerLegal) begin
            answer_d       = answerIn;
            answer_valid_d = 1'b1;
        end

        if (state_q == ARM) begin
            clr_cnt_d = clr_cnt_q + 8'd1;
        end

        if (state_q != ARM && state_d == ARM) begin
            tries_d = TW'(MAX_TRIES);
        end

        if (!modeSelect && state_q == PLAY && guess_edge) begin
            if (correct) begin
                evt_win_d = 1'b1;
            end else if (tries_q != '0) begin
                tries_d     = tries_q - TW'(1);
                evt_wrong_d = 1'b1;
                evt_lose_d  = (tries_q == TW'(1));
            end
        end

        play_clear_d  = (state_d == SETUP) || (state_d == ARM);
        play_enable_d = (state_d == PLAY);
    end

    // Thermometer of remaining tries: bit i lit while i < tries
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_led
            assign led_d[gi] = (32'(tries_d) > gi);
        end
    endgenerate

    assign answerOut  = answer_q;
    assign playClear  = play_clear_q;
    assign playEnable = play_enable_q;
    assign led_data   = led_q;
    assign evtWrong   = evt_wrong_q;
    assign evtWin     = evt_win_q;
    assign evtLose    = evt_lose_q;
    assign roundState = state_q;

endmodule
